// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: op codes, op-code width and flag bit positions.
package alu_pkg;

   localparam int OP_W    = 4;
   localparam int FLAGS_W = 3;

   localparam int FLAG_ZERO  = 0;
   localparam int FLAG_CARRY = 1;
   localparam int FLAG_OVF   = 2;

   typedef enum logic [OP_W-1:0] {
      OP_AND    = 4'd0,
      OP_NAND   = 4'd1,
      OP_OR     = 4'd2,
      OP_NOR    = 4'd3,
      OP_XOR    = 4'd4,
      OP_XNOR   = 4'd5,
      OP_NOT_A  = 4'd6,
      OP_NOT_B  = 4'd7,
      OP_ADD    = 4'd8,
      OP_SUB    = 4'd9,
      OP_INC_A  = 4'd10,
      OP_DEC_A  = 4'd11,
      OP_PASS_A = 4'd12
   } op_t;

endpackage

// File: rtl/alu_pipe_stage.sv
// One valid/ready register slice: holds a beat until downstream takes it, and
// refills in the same cycle it drains.
module alu_pipe_stage
   import alu_pkg::*;
#(
   parameter int PW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          up_valid,
   input  logic [PW-1:0] up_data,
   input  logic          dn_ready,
   output logic          dn_valid,
   output logic [PW-1:0] dn_data
);

   logic slot_free;

   // The slot can load when empty or when its current beat is leaving this cycle.
   assign slot_free = !dn_valid || dn_ready;

   // NOTE: state is updated with non-blocking assignments so every slice samples
   // its neighbours' pre-edge values; blocking here would shift beats through
   // several stages in one clock depending on evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         dn_valid <= 1'b0;
         // NOTE: the payload is reset as well, not just the valid bit, because the
         // last slice drives out_data/out_tag/out_flags directly and those must
         // read zero after reset.
         dn_data  <= '0;
      end else if (slot_free) begin
         dn_valid <= up_valid;
         if (up_valid) begin
            dn_data <= up_data;
         end
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU with ready/valid handshaking, STAGES register slices and a pass-through tag.
// Define ALU_FLAGS_EN to add the out_flags port ({ovf, carry, zero}) piped with each result.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH  = 6,
   parameter int STAGES = 2,
   parameter int TAG_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [OP_W-1:0]  in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_valid,
   input  logic             out_ready
`ifdef ALU_FLAGS_EN
  ,output logic [FLAGS_W-1:0] out_flags
`endif
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

`ifdef ALU_FLAGS_EN
   localparam int PAY_W = FLAGS_W + TAG_W + WIDTH;
`else
   localparam int PAY_W = TAG_W + WIDTH;
`endif

   // ---------------------------------------------------------------- ALU
   op_t              op;
   logic             is_sub;
   logic [WIDTH-1:0] arith_b;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] res;

   assign op      = op_t'(in_op);
   assign is_sub  = (op == OP_SUB) || (op == OP_DEC_A);
   assign arith_b = ((op == OP_INC_A) || (op == OP_DEC_A)) ? ONE : in_b;

`ifdef ALU_FLAGS_EN
   logic [WIDTH:0]     sum_ext;
   logic               is_arith;
   logic               carry;
   logic               ovf;
   logic [FLAGS_W-1:0] flags;

   // The extra top bit is carry-out for addition and borrow for subtraction.
   assign sum_ext  = is_sub ? ({1'b0, in_a} - {1'b0, arith_b})
                            : ({1'b0, in_a} + {1'b0, arith_b});
   assign sum      = sum_ext[WIDTH-1:0];
   assign carry    = sum_ext[WIDTH];
   assign is_arith = op inside {OP_ADD, OP_SUB, OP_INC_A, OP_DEC_A};
   assign ovf      = (is_sub ? (in_a[WIDTH-1] != arith_b[WIDTH-1])
                             : (in_a[WIDTH-1] == arith_b[WIDTH-1]))
                     && (sum[WIDTH-1] != in_a[WIDTH-1]);

   always_comb begin
      flags            = '0;
      flags[FLAG_ZERO] = (res == '0);
      if (is_arith) begin
         flags[FLAG_CARRY] = carry;
         flags[FLAG_OVF]   = ovf;
      end
   end
`else
   assign sum = is_sub ? (in_a - arith_b) : (in_a + arith_b);
`endif

   // NOTE: res gets a default before the case so every path assigns it;
   // without that, an unlisted op code would infer a latch.
   always_comb begin
      res = '0;
      case (op)
         OP_AND:    res = in_a & in_b;
         OP_NAND:   res = ~(in_a & in_b);
         OP_OR:     res = in_a | in_b;
         OP_NOR:    res = ~(in_a | in_b);
         OP_XOR:    res = in_a ^ in_b;
         OP_XNOR:   res = ~(in_a ^ in_b);
         OP_NOT_A:  res = ~in_a;
         OP_NOT_B:  res = ~in_b;
         OP_ADD,
         OP_SUB,
         OP_INC_A,
         OP_DEC_A:  res = sum;
         OP_PASS_A: res = in_a;
         default:   res = '0;
      endcase
   end

   // ----------------------------------------------------------- pipeline
   logic [STAGES:0]   vchain;
   logic [STAGES-1:0] dn_rdy;
   logic [PAY_W-1:0]  pay [STAGES+1];

   assign vchain[0] = in_valid;
`ifdef ALU_FLAGS_EN
   assign pay[0] = {flags, in_tag, res};
`else
   assign pay[0] = {in_tag, res};
`endif

   // A stage's beat leaves when the sink is ready or any later stage has a hole,
   // since every hole downstream compresses forward this cycle. Computing it from
   // registered valids keeps the ready path free of combinational chaining.
   always_comb begin
      dn_rdy = '0;
      for (int i = 0; i < STAGES; i++) begin
         dn_rdy[i] = out_ready;
         for (int j = i + 1; j < STAGES; j++) begin
            if (!vchain[j+1]) begin
               dn_rdy[i] = 1'b1;
            end
         end
      end
   end

   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      alu_pipe_stage #(
         .PW (PAY_W)
      ) u_stage (
         .clk      (clk),
         .rst      (rst),
         .up_valid (vchain[g]),
         .up_data  (pay[g]),
         .dn_ready (dn_rdy[g]),
         .dn_valid (vchain[g+1]),
         .dn_data  (pay[g+1])
      );
   end

   assign in_ready  = !rst && (!vchain[1] || dn_rdy[0]);
   assign out_valid = vchain[STAGES];

`ifdef ALU_FLAGS_EN
   assign {out_flags, out_tag, out_data} = pay[STAGES];
`else
   assign {out_tag, out_data} = pay[STAGES];
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed corner cases plus randomized traffic
// scored against an arithmetic reference model and an in-order expectation queue.
module tb_alu_pipe;

   localparam int WIDTH  = 6;
   localparam int STAGES = 2;
   localparam int TAG_W  = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [3:0]       in_op;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [TAG_W-1:0] in_tag;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out_data;
   logic [TAG_W-1:0] out_tag;
   logic             out_valid;
   logic             out_ready;
`ifdef ALU_FLAGS_EN
   logic [2:0]       out_flags;
`endif

   always #5 clk = ~clk;

   alu_pipe #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES),
      .TAG_W  (TAG_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_tag    (in_tag),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef ALU_FLAGS_EN
     ,.out_flags (out_flags)
`endif
   );

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [TAG_W-1:0] tag;
      logic [2:0]       flags;   // {ovf, carry, zero}
   } exp_t;

   exp_t exp_q[$];
   int   n_checks  = 0;
   int   n_pass    = 0;
   int   acc_count = 0;
   int   out_count = 0;

   logic             prev_hold = 1'b0;
   logic [WIDTH-1:0] prev_data;
   logic [TAG_W-1:0] prev_tag;
   logic             last_fire;
   logic [WIDTH-1:0] fire_data;
   logic [TAG_W-1:0] fire_tag;
   logic [2:0]       fire_flags;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   // Reference model: plain integer arithmetic, signed range test for overflow.
   function automatic exp_t model(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag);
      exp_t e;
      int m    = 1 << WIDTH;
      int half = m / 2;
      int ua   = int'(a);
      int ub   = int'(b);
      int sa   = (ua >= half) ? ua - m : ua;
      int sb   = (ub >= half) ? ub - m : ub;
      int r    = 0;
      int sr   = 0;
      bit arith = 1'b0;
      bit carry = 1'b0;
      bit ovf;
      case (op)
         4'd0:  r = ua & ub;
         4'd1:  r = ~(ua & ub);
         4'd2:  r = ua | ub;
         4'd3:  r = ~(ua | ub);
         4'd4:  r = ua ^ ub;
         4'd5:  r = ~(ua ^ ub);
         4'd6:  r = ~ua;
         4'd7:  r = ~ub;
         4'd8:  begin r = ua + ub; sr = sa + sb; arith = 1'b1; carry = (r >= m); end
         4'd9:  begin r = ua - ub; sr = sa - sb; arith = 1'b1; carry = (r < 0);  end
         4'd10: begin r = ua + 1;  sr = sa + 1;  arith = 1'b1; carry = (r >= m); end
         4'd11: begin r = ua - 1;  sr = sa - 1;  arith = 1'b1; carry = (r < 0);  end
         4'd12: r = ua;
         default: r = 0;
      endcase
      ovf     = arith && ((sr >= half) || (sr < -half));
      e.data  = WIDTH'(r & (m - 1));
      e.tag   = tag;
      e.flags = {ovf, carry, ((r & (m - 1)) == 0)};
      return e;
   endfunction

   // One clock: drive at the falling edge, observe 1 time unit later; the
   // handshakes seen here are the ones that complete at the next rising edge.
   task automatic step(input logic r, input logic v, input logic [3:0] op,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [TAG_W-1:0] tag, input logic ordy);
      exp_t e;
      @(negedge clk);
      rst = r; in_valid = v; in_op = op; in_a = a; in_b = b; in_tag = tag; out_ready = ordy;
      #1;
      last_fire = 1'b0;
      if (r) exp_q.delete();
      if (prev_hold) begin
         check("hold_valid", out_valid, 1);
         check("hold_data", out_data, prev_data);
         check("hold_tag", out_tag, prev_tag);
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("spurious_out", out_valid, 0);
         end else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_tag", out_tag, e.tag);
`ifdef ALU_FLAGS_EN
            check("out_flags", out_flags, e.flags);
            fire_flags = out_flags;
`endif
         end
         last_fire = 1'b1;
         fire_data = out_data;
         fire_tag  = out_tag;
         out_count++;
      end
      if (in_valid && in_ready) begin
         exp_q.push_back(model(op, a, b, tag));
         acc_count++;
      end
      prev_hold = out_valid && !out_ready && !r;
      prev_data = out_data;
      prev_tag  = out_tag;
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 1'b0, 4'd0, '0, '0, '0, ordy);
   endtask

   // Single op into an empty pipe: checks latency and the exact expected values.
   task automatic send_one(input string name, input logic [3:0] op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] tag,
                           input logic [WIDTH-1:0] exp_data, input logic [2:0] exp_flags);
      int lat = 0;
      step(1'b0, 1'b1, op, a, b, tag, 1'b1);
      check({name, "_accept"}, in_ready, 1);
      while (lat < 20) begin
         idle(1'b1);
         lat++;
         if (last_fire) break;
      end
      check({name, "_latency"}, lat, STAGES);
      check({name, "_data"}, fire_data, exp_data);
      check({name, "_tag"}, fire_tag, tag);
`ifdef ALU_FLAGS_EN
      check({name, "_flags"}, fire_flags, exp_flags);
`else
      if (exp_flags != fire_flags) begin end
`endif
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 64 && exp_q.size() != 0; i++) idle(1'b1);
      check(name, exp_q.size(), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int out0;
      int acc0;
      fire_flags = '0;
      rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;

      // Reset state
      step(1'b1, 1'b0, 4'd0, '0, '0, '0, 1'b0);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_tag", out_tag, 0);
`ifdef ALU_FLAGS_EN
      check("rst_out_flags", out_flags, 0);
`endif
      step(1'b1, 1'b0, 4'd0, '0, '0, '0, 1'b0);
      idle(1'b1);
      check("post_rst_in_ready", in_ready, 1);

      // Directed corner cases
      send_one("add_wrap", 4'd8,  6'h3F, 6'h01, 4'd5, 6'h00, 3'b011);
      send_one("sub_ovf",  4'd9,  6'h20, 6'h01, 4'd3, 6'h1F, 3'b100);
      send_one("op14",     4'd14, 6'h2A, 6'h15, 4'd7, 6'h00, 3'b001);
      send_one("inc_ovf",  4'd10, 6'h1F, 6'h00, 4'd1, 6'h20, 3'b100);
      send_one("dec_brw",  4'd11, 6'h00, 6'h00, 4'd2, 6'h3F, 3'b010);
      send_one("nand",     4'd1,  6'h0F, 6'h3C, 4'd4, 6'h33, 3'b000);

      // 16 back-to-back ops with the sink always ready
      out0 = out_count;
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, 4'($urandom_range(0, 15)), 6'($urandom), 6'($urandom), 4'(i), 1'b1);
         check("stream_in_ready", in_ready, 1);
      end
      for (int i = 0; i < STAGES; i++) idle(1'b1);
      check("stream_out_count", out_count - out0, 16);
      drain("stream_drain");

      // Backpressure: sink stalled for 5 cycles while the source keeps offering
      acc0 = acc_count;
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b1, 4'($urandom_range(0, 12)), 6'($urandom), 6'($urandom), 4'($urandom), 1'b0);
         if (k >= STAGES) check("bp_in_ready_low", in_ready, 0);
      end
      check("bp_accepts", acc_count - acc0, STAGES);
      drain("bp_drain");

      // Reset with two beats in flight
      step(1'b0, 1'b1, 4'd8, 6'h01, 6'h02, 4'hA, 1'b0);
      step(1'b0, 1'b1, 4'd9, 6'h05, 6'h03, 4'hB, 1'b0);
      step(1'b1, 1'b0, 4'd0, '0, '0, '0, 1'b0);
      check("mid_rst_in_ready", in_ready, 0);
      idle(1'b1);
      check("mid_rst_out_valid", out_valid, 0);
      for (int i = 0; i < 4; i++) begin
         idle(1'b1);
         check("no_stale_beat", out_valid, 0);
      end
      send_one("post_rst_add", 4'd8, 6'h10, 6'h05, 4'h9, 6'h15, 3'b000);

      // Randomized traffic with random sink backpressure
      acc0 = acc_count;
      for (int i = 0; i < 20000 && (acc_count - acc0) < 1000; i++) begin
         step(1'b0, ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
              6'($urandom), 6'($urandom), 4'($urandom), 1'($urandom));
      end
      check("rand_accepts", acc_count - acc0, 1000);
      drain("rand_drain");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
